redmule_w_sched: RTL and testbench

REDMULE_W_SCHED -- requirements
Module: redmule_w_sched

---
 rtl/redmule_w_sched.sv | 130 +++++++++++++
 tb/tb_redmule_w_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/redmule_w_sched.sv
// W-buffer scheduler: fills H rows from the streamer, then hands out tile_w
// column shifts to the engine, masking rows beyond the tile height.
`ifndef ARRAY_HEIGHT
`define ARRAY_HEIGHT 4
`endif

module redmule_w_sched #(
  parameter int unsigned Height = `ARRAY_HEIGHT,
  parameter int unsigned D      = 18,
  localparam int unsigned HW    = $clog2(Height) + 1,
  localparam int unsigned CW    = $clog2(D) + 1,
  localparam int unsigned RW    = $clog2(Height)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [HW-1:0]     tile_h_i,
  input  logic [CW-1:0]     tile_w_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  input  logic              shift_req_i,
  output logic              shift_gnt_o,
  output logic              load_o,
  output logic              shift_o,
  output logic [HW-1:0]     height_o,
  output logic [CW-1:0]     width_o,
  output logic [Height-1:0] zero_set_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [HW-1:0] height_q;
  logic [CW-1:0] width_q;
  logic          done_q, done_d;
  logic          latch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      height_q <= '0;
      width_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      if (latch) begin
        height_q <= tile_h_i;
        width_q  <= tile_w_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = 1'b0;
    latch     = 1'b0;
    w_ready_o = 1'b0;
    load_o    = 1'b0;
    shift_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          latch = 1'b1;
          if (tile_w_i == '0 || tile_h_i == '0) done_d = 1'b1;
          else                                  state_d = FILL;
        end
      end
      FILL: begin
        w_ready_o = 1'b1;
        load_o    = w_valid_i;
        if (load_o) begin
          if (row_q == RW'(Height - 1)) begin
            row_d   = '0;
            state_d = DRAIN;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      DRAIN: begin
        shift_o = shift_req_i;
        if (shift_o) begin
          if (col_q == width_q - CW'(1)) begin
            col_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything decided above, including strobes this cycle.
    if (clear_i) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      done_d  = 1'b0;
      latch   = 1'b0;
      load_o  = 1'b0;
      shift_o = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < Height; i++) begin
      zero_set_o[i] = (state_q == DRAIN) && (i >= 32'(height_q));
    end
  end

  assign shift_gnt_o = shift_o;
  assign height_o    = height_q;
  assign width_o     = width_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_redmule_w_sched.sv
// Randomized self-checking bench for redmule_w_sched against a tile-level
// model that tracks rows still to load and grants still to give.
module tb_redmule_w_sched;

  localparam int H = 4;
  localparam int D = 18;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clear_i, start_i, w_valid_i, shift_req_i;
  logic [2:0] tile_h_i;
  logic [4:0] tile_w_i;
  logic       w_ready_o, shift_gnt_o, load_o, shift_o, busy_o, done_o;
  logic [2:0] height_o;
  logic [4:0] width_o;
  logic [H-1:0] zero_set_o;

  redmule_w_sched #(.Height(H), .D(D)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .tile_h_i    (tile_h_i),
    .tile_w_i    (tile_w_i),
    .w_valid_i   (w_valid_i),
    .w_ready_o   (w_ready_o),
    .shift_req_i (shift_req_i),
    .shift_gnt_o (shift_gnt_o),
    .load_o      (load_o),
    .shift_o     (shift_o),
    .height_o    (height_o),
    .width_o     (width_o),
    .zero_set_o  (zero_set_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Tile-level model state
  int m_loads_left  = 0;
  int m_grants_left = 0;
  int m_h = 0, m_w = 0;
  bit m_done = 1'b0;
  int n_loads = 0, n_grants = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit in_fill();
    return m_loads_left > 0;
  endfunction

  function automatic bit in_drain();
    return m_loads_left == 0 && m_grants_left > 0;
  endfunction

  task automatic step(input bit st, input int th, input int tw,
                      input bit v, input bit rq, input bit cl);
    bit f, dr, e_load, e_shift;
    logic [H-1:0] e_zs;
    @(negedge clk_i);
    start_i = st; tile_h_i = 3'(th); tile_w_i = 5'(tw);
    w_valid_i = v; shift_req_i = rq; clear_i = cl;
    #1;
    f  = in_fill();
    dr = in_drain();
    e_load  = f && v && !cl;
    e_shift = dr && rq && !cl;
    for (int i = 0; i < H; i++) e_zs[i] = dr && (i >= m_h);
    check("w_ready", 32'(w_ready_o), 32'(f));
    check("load",    32'(load_o),    32'(e_load));
    check("shift",   32'(shift_o),   32'(e_shift));
    check("gnt",     32'(shift_gnt_o), 32'(e_shift));
    check("busy",    32'(busy_o),    32'(f || dr));
    check("done",    32'(done_o),    32'(m_done));
    check("zero_set", 32'(zero_set_o), 32'(e_zs));
    check("height",  32'(height_o),  32'(m_h));
    check("width",   32'(width_o),   32'(m_w));
    if (load_o)  n_loads++;
    if (shift_o) n_grants++;
    m_done = 1'b0;
    if (cl) begin
      m_loads_left = 0;
      m_grants_left = 0;
    end else if (!f && !dr) begin
      if (st) begin
        m_h = th; m_w = tw;
        if (th == 0 || tw == 0) m_done = 1'b1;
        else begin
          m_loads_left = H;
          m_grants_left = tw;
        end
      end
    end else if (e_load) begin
      m_loads_left--;
    end else if (e_shift) begin
      m_grants_left--;
      if (m_grants_left == 0) m_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rst_busy",  32'(busy_o), 0);
    check("rst_done",  32'(done_o), 0);
    check("rst_ready", 32'(w_ready_o), 0);
    check("rst_shift", 32'(shift_o), 0);
    check("rst_load",  32'(load_o), 0);
    check("rst_h",     32'(height_o), 0);
    check("rst_w",     32'(width_o), 0);
    check("rst_zs",    32'(zero_set_o), 0);
    m_loads_left = 0; m_grants_left = 0; m_h = 0; m_w = 0; m_done = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Runs a tile from start until idle; gaps are percent of idle cycles on the handshakes.
  task automatic run_tile(input int th, input int tw, input int gap_v, input int gap_r,
                          input bit clear_2nd, input bit start_in_fill, input int clr_pct);
    bit v, rq, cl, st;
    int cyc;
    bit aborted;
    n_loads = 0; n_grants = 0; aborted = 1'b0;
    step(1'b1, th, tw, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while ((in_fill() || in_drain() || m_done) && cyc < 300) begin
      v  = ($urandom_range(99) >= 32'(gap_v));
      rq = ($urandom_range(99) >= 32'(gap_r));
      cl = ($urandom_range(99) < 32'(clr_pct)) && (in_fill() || in_drain());
      if (clear_2nd && in_drain() && m_grants_left == m_w - 1) begin
        rq = 1'b1; cl = 1'b1;
      end
      st = start_in_fill && in_fill();
      if (cl) aborted = 1'b1;
      step(st, $urandom_range(1, H), $urandom_range(1, D), v, rq, cl);
      cyc++;
    end
    check("tile_timeout", 32'(cyc >= 300), 0);
    if (!aborted && th != 0 && tw != 0) begin
      check("load_count",  32'(n_loads), 32'(H));
      check("grant_count", 32'(n_grants), 32'(tw));
    end else if (th == 0 || tw == 0) begin
      check("zero_loads",  32'(n_loads), 0);
      check("zero_grants", 32'(n_grants), 0);
    end
  endtask

  initial begin
    rst_ni = 1'b1; clear_i = 1'b0; start_i = 1'b0; w_valid_i = 1'b0;
    shift_req_i = 1'b0; tile_h_i = '0; tile_w_i = '0;
    do_reset();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    run_tile(4, 18, 0, 0, 1'b0, 1'b0, 0);   // full tile, handshakes held
    run_tile(2, 5, 0, 0, 1'b0, 1'b0, 0);    // masked rows 2,3
    run_tile(3, 0, 0, 0, 1'b0, 1'b0, 0);    // empty width
    run_tile(0, 7, 0, 0, 1'b0, 1'b0, 0);    // empty height
    run_tile(4, 9, 50, 60, 1'b0, 1'b0, 0);  // gapped handshakes
    run_tile(1, 1, 30, 30, 1'b0, 1'b0, 0);  // single grant
    run_tile(3, 6, 0, 0, 1'b1, 1'b0, 0);    // clear on 2nd grant
    run_tile(2, 4, 20, 20, 1'b0, 1'b0, 0);
    run_tile(2, 8, 40, 0, 1'b0, 1'b1, 0);   // start pulsed during fill
    run_tile(4, D, 0, 0, 1'b0, 1'b0, 0);

    // asynchronous reset mid-tile
    step(1'b1, 3, 10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int th, tw;
      th = $urandom_range(0, H);
      tw = ($urandom_range(9) == 0) ? 1 : $urandom_range(0, D);
      run_tile(th, tw, $urandom_range(0, 70), $urandom_range(0, 70), 1'b0,
               $urandom_range(3) == 0, ($urandom_range(3) == 0) ? 3 : 0);
      if ($urandom_range(1) == 1) step(1'b0, 0, 0, 1'b1, 1'b1, $urandom_range(1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
